signed_shift_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_abs.sv | 22 ++
 rtl/signed_shift_multiplier.sv | 146 ++++++++++++++
 tb/tb_signed_shift_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the signed shift-add multiplier:
//                FSM state encoding, default operand width and the number
//                of shift-add iterations.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width; the product is twice as wide.
    localparam int c_W_DEFAULT = 4;

    // One shift-add iteration per multiplier bit.
    localparam int c_ITERS_DEFAULT = c_W_DEFAULT;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ABS  = 3'd1;
    localparam logic [2:0] c_ST_MUL  = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_abs.sv
`default_nettype none
// ============================================================================
//  Module      : mult_abs
//  Description : Combinational two's-complement magnitude. The result is
//                read as unsigned, so the most negative value maps to its
//                true magnitude (e.g. -8 -> 8 for W=4) without overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_abs #(
    parameter int W = mult_pkg::c_W_DEFAULT
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] mag
);

    // Negate only when the sign bit is set.
    always_comb begin
        mag = x[W-1] ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
    end

endmodule : mult_abs
`default_nettype wire

// File: rtl/signed_shift_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : signed_shift_multiplier
//  Description : Sequential signed W x W multiplier with a 2W-bit product.
//                Operands are reduced to magnitudes, multiplied by an
//                unsigned shift-add loop (one bit per cycle) and the sign
//                is restored at the end. Fixed latency of W+2 cycles from
//                the start sampling edge to done_multiply.
//                Optional feature macro: MULT_OVF_EN adds the ovf output,
//                flagging products outside the W-bit signed range.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_shift_multiplier
    import mult_pkg::*;
#(
    parameter int W = c_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           start,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done_multiply
`ifdef MULT_OVF_EN
    ,
    output logic           ovf
`endif
);

    // Counter wide enough to hold W-1; at least one bit.
    localparam int                c_CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_mag_a;
    logic [W-1:0]       r_mag_b;
    logic               r_neg;
    logic [2*W-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*W-1:0]     r_p;

    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [2*W-1:0]     w_addend;
    logic [2*W-1:0]     w_p_fix;

    mult_abs #(.W(W)) u_abs_a (
        .x   (r_a),
        .mag (w_mag_a)
    );

    mult_abs #(.W(W)) u_abs_b (
        .x   (r_b),
        .mag (w_mag_b)
    );

    // Shifted, zero-extended multiplicand and sign-corrected product.
    always_comb begin
        w_addend = {{W{1'b0}}, r_mag_a} << r_cnt;
        w_p_fix  = r_neg ? (~r_acc + {{(2*W-1){1'b0}}, 1'b1}) : r_acc;
    end

    // Main FSM: operand capture, magnitude, shift-add loop and sign fix.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else if (start) begin
            // A start in any state (re)launches; an aborted run never
            // reaches FIX so p keeps its previous value.
            r_a     <= a;
            r_b     <= b;
            r_state <= c_ST_ABS;
        end else begin
            case (r_state)
                c_ST_ABS: begin
                    r_mag_a <= w_mag_a;
                    r_mag_b <= w_mag_b;
                    r_neg   <= r_a[W-1] ^ r_b[W-1];
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= c_ST_MUL;
                end
                c_ST_MUL: begin
                    if (r_mag_b[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_p     <= w_p_fix;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy          = (r_state != c_ST_IDLE);
        done_multiply = (r_state == c_ST_DONE);
        p             = r_p;
    end

`ifdef MULT_OVF_EN
    logic r_ovf;

    // Overflow: the top W+1 bits of the product are not all identical,
    // i.e. the value does not fit a W-bit signed number.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!start && r_state == c_ST_FIX) begin
            r_ovf <= !((&w_p_fix[2*W-1:W-1]) || (~|w_p_fix[2*W-1:W-1]));
        end
    end

    // Registered overflow flag to the port.
    always_comb begin
        ovf = r_ovf;
    end
`endif

endmodule : signed_shift_multiplier
`default_nettype wire

// File: tb/tb_signed_shift_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_shift_multiplier
//  Description : Self-checking bench for signed_shift_multiplier: directed
//                cases, abort/restart, mid-operation reset and randomized
//                operands checked against an arithmetic reference.
//                Build with MULT_OVF_EN defined to also check ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_shift_multiplier;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           start;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done_multiply;
`ifdef MULT_OVF_EN
    logic           ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    signed_shift_multiplier #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .start         (start),
        .p             (p),
        .busy          (busy),
        .done_multiply (done_multiply)
`ifdef MULT_OVF_EN
        ,
        .ovf           (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer multiplication, truncated to 2W bits.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) * int'($signed(y));
        return r[2*W-1:0];
    endfunction

    // Reference: product outside the W-bit signed range.
    function automatic logic ref_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y);
        int r;
        r = int'($signed(x)) * int'($signed(y));
        return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
    endfunction

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one sampling edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Wait (bounded) for done, then check latency, busy and result.
    task automatic wait_done(input logic [W-1:0] x, input logic [W-1:0] y,
                             input string tag);
        int  n;
        bit  seen;
        logic [2*W-1:0] hold;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            check_eq({tag, "_busy"}, busy, 1);
            tick();
            n++;
            if (done_multiply === 1'b1) seen = 1'b1;
            else a = W'($urandom);
        end
        check_eq({tag, "_latency"}, n, 6);
        check_eq({tag, "_p"}, p, ref_prod(x, y));
`ifdef MULT_OVF_EN
        check_eq({tag, "_ovf"}, ovf, ref_ovf(x, y));
`endif
        hold = p;
        tick();
        check_eq({tag, "_done_pulse"}, done_multiply, 0);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_p_hold"}, p, hold);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag);
        launch(x, y);
        wait_done(x, y, tag);
    endtask

    initial begin
        logic [2*W-1:0] hold;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_p", p, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done_multiply, 0);
`ifdef MULT_OVF_EN
        check_eq("rst_ovf", ovf, 0);
`endif

        // Directed cases
        run_op(4'd3, 4'd2, "3x2");
        check_eq("3x2_value", p, 8'h06);
        run_op(4'hD, 4'd2, "m3x2");
        check_eq("m3x2_value", p, 8'hFA);
        run_op(4'd7, 4'h8, "7xm8");
        check_eq("7xm8_value", p, 8'hC8);
        run_op(4'h8, 4'h8, "m8xm8");
        check_eq("m8xm8_value", p, 8'h40);
        run_op(4'd0, 4'hB, "0xm5");
        check_eq("0xm5_value", p, 8'h00);
        run_op(4'd3, 4'd3, "3x3");
        check_eq("3x3_value", p, 8'h09);
        run_op(4'h8, 4'd1, "m8x1");

        // Operands changing without start must not disturb p
        hold = p;
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
            check_eq("idle_done", done_multiply, 0);
        end
        check_eq("idle_p_hold", p, hold);

        // Abort/restart: second start three cycles after the first
        launch(4'd3, 4'd3);
        tick();
        check_eq("abort_no_done1", done_multiply, 0);
        tick();
        check_eq("abort_no_done2", done_multiply, 0);
        check_eq("abort_p_kept", p, hold);
        launch(4'hE, 4'd3);
        wait_done(4'hE, 4'd3, "restart");
        check_eq("restart_value", p, 8'hFA);

        // Reset during MUL
        launch(4'd3, 4'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_p", p, 0);
        check_eq("midrst_done", done_multiply, 0);
`ifdef MULT_OVF_EN
        check_eq("midrst_ovf", ovf, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("midrst_quiet", done_multiply, 0);
        end
        run_op(4'd5, 4'd1, "5x1");
        check_eq("5x1_value", p, 8'h05);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_signed_shift_multiplier
`default_nettype wire
